plat_land_scan: RTL and testbench
=================================

Name: plat_land_scan

Overview:
- Consumer of the per-block platform table that the block generator drives (plat_relative_x/y, plat_len, camera_y, block_switch).
- On each physics request, the block scans all platforms of the current block sequentially, one per cycle.
- It reports whether the falling character lands on a platform, which platform it is, and the snapped landing height.
- Sits between the block generator and the character physics FSM.

Parameters:
- PLATFORM_NUM_PER_BLOCK, 7, platforms per block (scan length).
- PHY_WIDTH, 14, width of one platform x/y field.
- BLOCK_WIDTH, 480, vertical pixels per block; block base = camera_y*BLOCK_WIDTH.
- BLOCK_LEN_WIDTH, 4, width of one plat_len field.
- TILE_W, 8, pixels per plat_len unit.
- PLAT_H, 8, platform thickness; top surface = plat_y + PLAT_H.
- CHAR_W, 16, character width in pixels.
- LAND_TOL, 6, pixels the feet may sink below a top and still snap.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  scan request pulse; ignored while busy.
- abs_char_x  in  PHY_WIDTH+1 (signed)  character left edge.
- abs_char_y  in  PHY_WIDTH+1 (signed)  character feet y (up positive).
- falling  in  1  vertical velocity < 0.
- camera_y  in  5  current block index.
- plat_relative_x  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform x.
- plat_relative_y  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform y.
- plat_len  in  PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH  packed lengths.
- block_switch  in  1  block changed this cycle.
- busy  out  1  scan in progress.
- done  out  1  one-cycle result strobe.
- hit  out  1  landing found.
- aborted  out  1  scan killed by block_switch.
- hit_idx  out  3  index of the landing platform.
- land_y  out  PHY_WIDTH+1 (signed)  absolute snapped feet y.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset: FSM goes to IDLE. busy, done, hit, aborted, hit_idx and land_y are all 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches abs_char_x, falling, the three platform buses and base = camera_y*BLOCK_WIDTH.
  - It also latches rel_y = abs_char_y - base, signed PHY_WIDTH+2 bits.
  - Clears idx, best_valid, aborted. Goes to SCAN; busy=1 from the next cycle.
- SCAN: evaluate platform idx each cycle.
  - Define x0 = plat_x[idx], x1 = x0 + plat_len[idx]*TILE_W, top = plat_y[idx] + PLAT_H.
  - Candidate when all of the following hold:
    - falling=1
    - plen != 0
    - char_x + CHAR_W > x0
    - char_x < x1
    - top - LAND_TOL <= rel_y <= top
  - All comparisons are signed, PHY_WIDTH+2 bits; char_x < 0 is legal.
  - Selection: keep the candidate with the largest top; on equal top, the lowest idx wins (strict > compare).
  - After idx = PLATFORM_NUM_PER_BLOCK-1, go to DONE.
  - block_switch=1 in any SCAN cycle: set aborted and go to DONE immediately, discarding candidates.
- DONE (one cycle):
  - done=1, busy=0.
  - hit = best_valid & ~aborted.
  - hit_idx = best idx; land_y = base + best_top. Both are 0 when hit=0.
  - Return to IDLE. A start in the DONE cycle is ignored.
- Outputs hit, hit_idx, land_y and aborted hold their value until the next DONE or reset. done is a one-cycle pulse.
- Latency: start at cycle N, done at cycle N+PLATFORM_NUM_PER_BLOCK+1 (N+8 by default). Throughput is one scan per 9 cycles.
- Changes on the input platform buses after the latch have no effect on a running scan.
- Reset during SCAN returns to IDLE the next cycle with no done.

Optional Feature:
- Macro: PLAT_WALL_EN.
- When defined, adds two output ports, wall_l and wall_r (reset 0, updated at DONE).
- wall_r=1 when some platform satisfies both:
  - vertical overlap: plat_y <= rel_y < top
  - char_x + CHAR_W is in [x0, x0+LAND_TOL]
- wall_l=1 is the mirror case with char_x in [x1-LAND_TOL, x1].
- Walls are evaluated regardless of falling and are forced to 0 when aborted.
- Undefined: the ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
1. Block-0 table, camera_y=0, char_x=300, char_y=66, falling=1, start -> done 8 cycles later, hit=1, hit_idx=0, land_y=68.
2. Same as 1 with falling=0 -> done, hit=0, hit_idx=0, land_y=0.
3. Edge case with platform 0 x=280, len=10: char_x=264 -> hit=0 (264+16=280 is not > 280). char_x=359 -> hit=1. char_x=360 -> hit=0.
4. Platforms 2 and 5 both candidate, tops 70 and 72, char_y=68 -> hit_idx=5, land_y=72. With equal tops 70/70 -> hit_idx=2.
5. camera_y=1, char_y=546 (rel 66), block-0 table -> hit=1, land_y=548. Pulse block_switch at the 3rd SCAN cycle -> done that next cycle, aborted=1, hit=0.
6. start pulsed while busy and in the DONE cycle -> ignored. sys_rst mid-SCAN -> no done, all outputs 0, a fresh start works normally.

Source files
------------

// File: rtl/plat_land_scan.sv
// plat_land_scan: sequential platform landing scan over the current block's table.
// Optional PLAT_WALL_EN adds wall_l/wall_r side-contact outputs.
module plat_land_scan #(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH = 14,
  parameter int BLOCK_WIDTH = 480,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int TILE_W = 8,
  parameter int PLAT_H = 8,
  parameter int CHAR_W = 16,
  parameter int LAND_TOL = 6
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic start,
  input  logic [PHY_WIDTH:0] abs_char_x,
  input  logic [PHY_WIDTH:0] abs_char_y,
  input  logic falling,
  input  logic [4:0] camera_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_x,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
  input  logic block_switch,
  output logic busy,
  output logic done,
  output logic hit,
  output logic aborted,
  output logic [2:0] hit_idx,
  output logic [PHY_WIDTH:0] land_y
`ifdef PLAT_WALL_EN
  ,
  output logic wall_l,
  output logic wall_r
`endif
);
  localparam int W = PHY_WIDTH + 2;
  localparam logic signed [W-1:0] CW = W'(CHAR_W);
  localparam logic signed [W-1:0] TOL = W'(LAND_TOL);
  localparam logic signed [W-1:0] PH = W'(PLAT_H);
  localparam logic [W-1:0] TW = W'(TILE_W);
  localparam logic [W-1:0] BW = W'(BLOCK_WIDTH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] idx, best_idx, nb_idx;
  logic signed [W-1:0] cx, rel_y, base, best_top, nb_top;
  logic signed [W-1:0] base_in, x0, x1, y0, top, land_sum;
  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] px, py;
  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] pl;
  logic [BLOCK_LEN_WIDTH-1:0] plen;
  logic fall, best_valid, nb_valid, cand, take, last;
`ifdef PLAT_WALL_EN
  logic wl_acc, wr_acc, wl_c, wr_c;
`endif
  always_comb begin
    base_in = $signed({{(W-5){1'b0}}, camera_y} * BW);
    plen = pl[idx*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
    x0 = $signed({2'b00, px[idx*PHY_WIDTH +: PHY_WIDTH]});
    y0 = $signed({2'b00, py[idx*PHY_WIDTH +: PHY_WIDTH]});
    x1 = x0 + $signed({{(W-BLOCK_LEN_WIDTH){1'b0}}, plen} * TW);
    top = y0 + PH;
    cand = fall && plen != '0 && cx + CW > x0 && cx < x1 && rel_y >= top - TOL && rel_y <= top;
    // strict compare keeps the lowest index on equal tops
    take = cand && (!best_valid || top > best_top);
    nb_valid = best_valid | cand;
    nb_top = take ? top : best_top;
    nb_idx = take ? idx : best_idx;
    land_sum = base + nb_top;
    last = idx == 3'(PLATFORM_NUM_PER_BLOCK - 1);
`ifdef PLAT_WALL_EN
    wr_c = rel_y >= y0 && rel_y < top && cx + CW >= x0 && cx + CW <= x0 + TOL;
    wl_c = rel_y >= y0 && rel_y < top && cx >= x1 - TOL && cx <= x1;
`endif
    state_nx = state == IDLE ? (start ? SCAN : IDLE) :
               state == SCAN ? (block_switch || last ? DONE : SCAN) : IDLE;
    busy = state == SCAN;
    done = state == DONE;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      idx <= '0;
      best_valid <= 1'b0;
      best_top <= '0;
      best_idx <= '0;
      cx <= '0;
      rel_y <= '0;
      base <= '0;
      fall <= 1'b0;
      px <= '0;
      py <= '0;
      pl <= '0;
      hit <= 1'b0;
      aborted <= 1'b0;
      hit_idx <= '0;
      land_y <= '0;
`ifdef PLAT_WALL_EN
      wl_acc <= 1'b0;
      wr_acc <= 1'b0;
      wall_l <= 1'b0;
      wall_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cx <= $signed({abs_char_x[PHY_WIDTH], abs_char_x});
        rel_y <= $signed({abs_char_y[PHY_WIDTH], abs_char_y}) - base_in;
        base <= base_in;
        fall <= falling;
        px <= plat_relative_x;
        py <= plat_relative_y;
        pl <= plat_len;
        idx <= '0;
        best_valid <= 1'b0;
        best_top <= '0;
        best_idx <= '0;
`ifdef PLAT_WALL_EN
        wl_acc <= 1'b0;
        wr_acc <= 1'b0;
`endif
      end
      if (state == SCAN) begin
        idx <= idx + 3'd1;
        best_valid <= nb_valid;
        best_top <= nb_top;
        best_idx <= nb_idx;
`ifdef PLAT_WALL_EN
        wl_acc <= wl_acc | wl_c;
        wr_acc <= wr_acc | wr_c;
`endif
        if (block_switch || last) begin
          aborted <= block_switch;
          hit <= nb_valid && !block_switch;
          hit_idx <= nb_valid && !block_switch ? nb_idx : 3'd0;
          land_y <= nb_valid && !block_switch ? land_sum[PHY_WIDTH:0] : '0;
`ifdef PLAT_WALL_EN
          wall_l <= !block_switch && (wl_acc | wl_c);
          wall_r <= !block_switch && (wr_acc | wr_c);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_plat_land_scan.sv
// tb_plat_land_scan: directed landing-scan vectors with hand-computed results.
module tb_plat_land_scan;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic start = 1'b0;
  logic [14:0] abs_char_x = '0;
  logic [14:0] abs_char_y = '0;
  logic falling = 1'b0;
  logic [4:0] camera_y = '0;
  logic [97:0] plat_relative_x = '0;
  logic [97:0] plat_relative_y = '0;
  logic [27:0] plat_len = '0;
  logic block_switch = 1'b0;
  logic busy, done, hit, aborted;
  logic [2:0] hit_idx;
  logic [14:0] land_y;
  int n_checks = 0;
  int n_fail = 0;
  int tx [7];
  int ty [7];
  int tl [7];
  int lat;

  plat_land_scan dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .abs_char_x(abs_char_x), .abs_char_y(abs_char_y), .falling(falling),
    .camera_y(camera_y), .plat_relative_x(plat_relative_x),
    .plat_relative_y(plat_relative_y), .plat_len(plat_len),
    .block_switch(block_switch), .busy(busy), .done(done), .hit(hit),
    .aborted(aborted), .hit_idx(hit_idx), .land_y(land_y)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 7; i++) begin
      plat_relative_x[i*14 +: 14] = 14'(tx[i]);
      plat_relative_y[i*14 +: 14] = 14'(ty[i]);
      plat_len[i*4 +: 4] = 4'(tl[i]);
    end
  endtask

  task automatic tbl0();
    tx[0] = 280; ty[0] = 60; tl[0] = 10;
    for (int i = 1; i < 7; i++) begin
      tx[i] = i * 50; ty[i] = 200 + i * 30; tl[i] = 3;
    end
    load();
  endtask

  // start pulse, then wait for done; side events keyed to cycles after start
  task automatic run(input int bs_at, input int rst_at, input int st_at, input bit scr, output int n);
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0; n = 1;
    while (!done && n < 20) begin
      if (n == bs_at) block_switch = 1'b1;
      if (n == rst_at) sys_rst = 1'b1;
      if (n == st_at) start = 1'b1;
      if (n == 2 && scr) begin
        plat_relative_x = '0;
        plat_len = '1;
      end
      @(negedge sys_clk);
      block_switch = 1'b0; sys_rst = 1'b0; start = 1'b0;
      n++;
    end
  endtask

  task automatic expect_res(input string tag, input int l, input bit h, input int idx, input int ly, input bit ab);
    check({tag, "_lat"}, lat, l);
    check({tag, "_done"}, done, 1);
    check({tag, "_hit"}, hit, h);
    check({tag, "_idx"}, hit_idx, idx);
    check({tag, "_land"}, land_y, ly);
    check({tag, "_abort"}, aborted, ab);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_abort", aborted, 0);
    check("rst_idx", hit_idx, 0);
    check("rst_land", land_y, 0);
    sys_rst = 1'b0;
    tbl0();
    abs_char_x = 15'd300; abs_char_y = 15'd66; falling = 1'b1;
    run(0, 0, 0, 0, lat);
    expect_res("t1", 8, 1, 0, 68, 0);
    falling = 1'b0;
    run(0, 0, 0, 0, lat);
    expect_res("t2", 8, 0, 0, 0, 0);
    falling = 1'b1;
    abs_char_x = 15'd264; run(0, 0, 0, 0, lat); expect_res("t3a", 8, 0, 0, 0, 0);
    abs_char_x = 15'd359; run(0, 0, 0, 0, lat); expect_res("t3b", 8, 1, 0, 68, 0);
    abs_char_x = 15'd360; run(0, 0, 0, 0, lat); expect_res("t3c", 8, 0, 0, 0, 0);
    abs_char_x = 15'd300;
    abs_char_y = 15'd62; run(0, 0, 0, 0, lat); expect_res("t3tol", 8, 1, 0, 68, 0);
    abs_char_y = 15'd61; run(0, 0, 0, 0, lat); expect_res("t3deep", 8, 0, 0, 0, 0);
    abs_char_y = 15'd69; run(0, 0, 0, 0, lat); expect_res("t3above", 8, 0, 0, 0, 0);
    tx[0] = 0; tl[0] = 2; abs_char_x = -15'sd10; abs_char_y = 15'd66; load();
    run(0, 0, 0, 0, lat); expect_res("t3neg", 8, 1, 0, 68, 0);
    tbl0();
    ty[0] = 300;
    tx[2] = 280; ty[2] = 62; tl[2] = 10;
    tx[5] = 280; ty[5] = 64; tl[5] = 10;
    load();
    abs_char_x = 15'd300; abs_char_y = 15'd68;
    run(0, 0, 0, 0, lat); expect_res("t4hi", 8, 1, 5, 72, 0);
    ty[5] = 62; load();
    run(0, 0, 0, 0, lat); expect_res("t4eq", 8, 1, 2, 70, 0);
    tbl0();
    camera_y = 5'd1; abs_char_y = 15'd546;
    run(0, 0, 0, 0, lat); expect_res("t5", 8, 1, 0, 548, 0);
    run(3, 0, 0, 0, lat); expect_res("t5abort", 4, 0, 0, 0, 1);
    run(0, 0, 0, 1, lat); expect_res("t5latch", 8, 1, 0, 548, 0);
    tbl0();
    run(0, 0, 3, 0, lat); expect_res("t6busy", 8, 1, 0, 548, 0);
    start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    check("t6dn_busy", busy, 0);
    @(negedge sys_clk);
    check("t6dn_busy2", busy, 0);
    check("t6dn_done", done, 0);
    check("t6dn_hold", land_y, 548);
    run(0, 3, 0, 0, lat);
    check("t6rst_nodone", lat, 20);
    check("t6rst_busy", busy, 0);
    check("t6rst_hit", hit, 0);
    check("t6rst_land", land_y, 0);
    check("t6rst_idx", hit_idx, 0);
    check("t6rst_abort", aborted, 0);
    run(0, 0, 0, 0, lat); expect_res("t6fresh", 8, 1, 0, 548, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
